// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit pipelined CPU
package cpu_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W = 4;
  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;
  typedef enum logic [1:0] {IDLE, BUSY, HALT} ex_mem_state_t;
endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: data-memory request/acknowledge bus (master = EX/MEM stage, slave = memory)
interface ex_mem_stage_if #(parameter int DATA_W = cpu_pkg::DEF_DATA_W);
  logic dmem_req;
  logic dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/ex_mem_stage_dmem_handshake.sv
// dmem_handshake: EX/MEM control FSM, pending flush, req/stall/done generation, optional stall counter (EX_MEM_STALL_CNT_EN)
module dmem_handshake
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ack,
  input  logic             ex_memop,
  input  logic             ex_hlt,
  input  logic             mem_valid,
  input  logic             mem_memop,
  input  logic             mem_hlt,
  output logic             load,
  output logic             bubble,
  output logic             req,
  output logic             stall_n,
  output logic             mem_done,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);
  ex_mem_state_t state, state_nx;
  logic flush_pend;
  always_comb begin
    load = state == IDLE || (state == BUSY && ack);
    bubble = flush || flush_pend;
    state_nx = !load ? state : bubble ? IDLE : ex_memop ? BUSY : ex_hlt ? HALT : IDLE;
    req = state == BUSY;
    stall_n = load;
    mem_done = state == IDLE ? mem_valid && !mem_memop && !mem_hlt : state == BUSY ? ack : !halted;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      flush_pend <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= state_nx;
      flush_pend <= !load && (flush_pend || (req && flush));
      halted <= state == HALT;
    end
`ifdef EX_MEM_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (req && !ack && !(&cnt)) cnt <= cnt + 1'b1;
  assign stall_cycles = cnt;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with data-memory handshake and upstream stall (optional EX_MEM_STALL_CNT_EN)
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_WriteReg,
  input  logic              ex_mem_write,
  input  logic              ex_memread,
  input  logic              ex_data_mux,
  input  logic              ex_hlt,
  ex_mem_stage_if.master    dmem,
  output logic              stall_n,
  output logic              mem_valid,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_WriteReg,
  output logic              mem_data_mux,
  output logic              mem_hlt,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);
  localparam int PW = 2 * DATA_W + REG_W + 6;
  logic [PW-1:0] pipe;
  logic [DATA_W-1:0] mem_rt_data;
  logic mem_mem_write, mem_memread, load, bubble, req;
  assign {mem_valid, mem_alu_result, mem_rt_data, mem_rd, mem_WriteReg, mem_mem_write, mem_memread,
          mem_data_mux, mem_hlt} = pipe;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe <= '0;
    else if (load) pipe <= bubble ? '0 : {1'b1, ex_alu_result, ex_rt_data, ex_rd, ex_WriteReg, ex_mem_write,
                                          ex_memread, ex_data_mux, ex_hlt};
  dmem_handshake #(.CNT_W(CNT_W)) u_hs (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .ack(dmem.dmem_ack),
    .ex_memop(ex_memread | ex_mem_write),
    .ex_hlt(ex_hlt),
    .mem_valid(mem_valid),
    .mem_memop(mem_memread | mem_mem_write),
    .mem_hlt(mem_hlt),
    .load(load),
    .bubble(bubble),
    .req(req),
    .stall_n(stall_n),
    .mem_done(mem_done),
    .halted(halted),
    .stall_cycles(stall_cycles)
  );
  assign dmem.dmem_req = req;
  assign dmem.dmem_we = mem_mem_write;
  assign dmem.dmem_addr = mem_alu_result;
  assign dmem.dmem_wdata = mem_rt_data;
  assign mem_rdata = req && dmem.dmem_ack ? dmem.dmem_rdata : '0;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed table-driven and sequence checks of ex_mem_stage
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic rst_n, flush;
  logic [15:0] ex_alu_result, ex_rt_data;
  logic [3:0] ex_rd;
  logic ex_WriteReg, ex_mem_write, ex_memread, ex_data_mux, ex_hlt;
  logic stall_n, mem_valid, mem_done, mem_WriteReg, mem_data_mux, mem_hlt, halted;
  logic [15:0] mem_alu_result, mem_rdata, stall_cycles;
  logic [3:0] mem_rd;
  int checks = 0;
  int errors = 0;
  ex_mem_stage_if #(.DATA_W(16)) dmem ();
  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_alu_result(ex_alu_result), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd),
    .ex_WriteReg(ex_WriteReg), .ex_mem_write(ex_mem_write), .ex_memread(ex_memread),
    .ex_data_mux(ex_data_mux), .ex_hlt(ex_hlt), .dmem(dmem),
    .stall_n(stall_n), .mem_valid(mem_valid), .mem_done(mem_done),
    .mem_alu_result(mem_alu_result), .mem_rd(mem_rd), .mem_WriteReg(mem_WriteReg),
    .mem_data_mux(mem_data_mux), .mem_hlt(mem_hlt), .mem_rdata(mem_rdata),
    .halted(halted), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] alu;
    logic [3:0]  rd;
    logic        wr, dm, fl;
    logic        e_valid;
    logic [15:0] e_alu;
    logic [3:0]  e_rd;
    logic        e_wr, e_dm, e_done;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ex(input logic [15:0] alu, input logic [15:0] rt, input logic [3:0] rd,
                        input logic wr, input logic mw, input logic mr, input logic dm, input logic hlt);
    ex_alu_result = alu; ex_rt_data = rt; ex_rd = rd; ex_WriteReg = wr;
    ex_mem_write = mw; ex_memread = mr; ex_data_mux = dm; ex_hlt = hlt;
  endtask
  task automatic mem_op(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int waits, input logic [15:0] rdata);
    set_ex(addr, wdata, 4'd5, !we, we, !we, !we, 1'b0);
    cyc();
    set_ex(16'h0777, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", dmem.dmem_req, 1);
      chk("wait_stall_n", stall_n, 0);
      chk("wait_done", mem_done, 0);
      chk("wait_addr", dmem.dmem_addr, addr);
      chk("wait_we", dmem.dmem_we, we);
      if (we) chk("wait_wdata", dmem.dmem_wdata, wdata);
      cyc();
    end
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = rdata;
    #1;
    chk("ack_done", mem_done, 1);
    chk("ack_stall_n", stall_n, 1);
    chk("ack_rdata", mem_rdata, rdata);
    cyc();
    dmem.dmem_ack = 1'b0;
    chk("after_ack_req", dmem.dmem_req, 0);
    chk("after_ack_next", mem_alu_result, 16'h0777);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{16'h1234, 4'd3, 1, 0, 0, 1, 16'h1234, 4'd3, 1, 0, 1};
    vecs[1] = '{16'hFFFF, 4'd15, 1, 1, 0, 1, 16'hFFFF, 4'd15, 1, 1, 1};
    vecs[2] = '{16'hAAAA, 4'd9, 1, 1, 1, 0, 16'h0000, 4'd0, 0, 0, 0};
    vecs[3] = '{16'h0000, 4'd0, 0, 0, 0, 1, 16'h0000, 4'd0, 0, 0, 1};
    vecs[4] = '{16'h8001, 4'd7, 1, 0, 0, 1, 16'h8001, 4'd7, 1, 0, 1};
    vecs[5] = '{16'h5555, 4'd1, 0, 1, 1, 0, 16'h0000, 4'd0, 0, 0, 0};
    rst_n = 1'b0; flush = 1'b0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 16'h0;
    set_ex(16'h0, 16'h0, 4'd0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall_n", stall_n, 1);
    chk("rst_req", dmem.dmem_req, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_alu", mem_alu_result, 0);
    chk("rst_cnt", stall_cycles, 0);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      set_ex(vecs[i].alu, 16'h0, vecs[i].rd, vecs[i].wr, 0, 0, vecs[i].dm, 0);
      flush = vecs[i].fl;
      cyc();
      chk("vec_valid", mem_valid, vecs[i].e_valid);
      chk("vec_alu", mem_alu_result, vecs[i].e_alu);
      chk("vec_rd", mem_rd, vecs[i].e_rd);
      chk("vec_wr", mem_WriteReg, vecs[i].e_wr);
      chk("vec_dm", mem_data_mux, vecs[i].e_dm);
      chk("vec_done", mem_done, vecs[i].e_done);
      chk("vec_req", dmem.dmem_req, 0);
      chk("vec_stall_n", stall_n, 1);
    end
    flush = 1'b0;
    mem_op(1'b0, 16'h0040, 16'h0, 3, 16'hBEEF);
    set_ex(16'h0100, 16'hCAFE, 4'd0, 0, 1, 0, 0, 0);
    cyc();
    set_ex(16'h0200, 16'h0000, 4'd6, 1, 0, 1, 1, 0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 16'h0;
    #1;
    chk("sw_req", dmem.dmem_req, 1);
    chk("sw_we", dmem.dmem_we, 1);
    chk("sw_addr", dmem.dmem_addr, 16'h0100);
    chk("sw_wdata", dmem.dmem_wdata, 16'hCAFE);
    chk("sw_done", mem_done, 1);
    cyc();
    set_ex(16'h0011, 16'h0, 4'd1, 1, 0, 0, 0, 0);
    dmem.dmem_rdata = 16'h1357;
    #1;
    chk("lw_req", dmem.dmem_req, 1);
    chk("lw_we", dmem.dmem_we, 0);
    chk("lw_addr", dmem.dmem_addr, 16'h0200);
    chk("lw_done", mem_done, 1);
    chk("lw_rdata", mem_rdata, 16'h1357);
    cyc();
    dmem.dmem_ack = 1'b0;
    chk("b2b_idle_req", dmem.dmem_req, 0);
    chk("b2b_next_alu", mem_alu_result, 16'h0011);
    chk("b2b_next_done", mem_done, 1);
    chk("idle_rdata", mem_rdata, 0);
    set_ex(16'h0040, 16'h0, 4'd5, 1, 0, 1, 1, 0);
    cyc();
    set_ex(16'h0022, 16'h0, 4'd4, 1, 0, 0, 0, 0);
    flush = 1'b1;
    #1;
    chk("fl_req", dmem.dmem_req, 1);
    cyc();
    flush = 1'b0;
    chk("fl_req2", dmem.dmem_req, 1);
    chk("fl_stall_n", stall_n, 0);
    cyc();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 16'h4242;
    #1;
    chk("fl_done", mem_done, 1);
    chk("fl_rdata", mem_rdata, 16'h4242);
    cyc();
    dmem.dmem_ack = 1'b0;
    chk("fl_bubble_valid", mem_valid, 0);
    chk("fl_bubble_done", mem_done, 0);
    chk("fl_bubble_alu", mem_alu_result, 0);
    cyc();
    chk("fl_cleared_valid", mem_valid, 1);
    chk("fl_cleared_alu", mem_alu_result, 16'h0022);
    set_ex(16'h0050, 16'h0, 4'd5, 1, 0, 1, 1, 0);
    cyc();
    set_ex(16'h0033, 16'h0, 4'd4, 1, 0, 0, 0, 0);
    flush = 1'b1; dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 16'h9999;
    #1;
    chk("flack_done", mem_done, 1);
    cyc();
    flush = 1'b0; dmem.dmem_ack = 1'b0;
    chk("flack_bubble", mem_valid, 0);
    cyc();
    chk("flack_next", mem_alu_result, 16'h0033);
    set_ex(16'h0000, 16'h0, 4'd0, 0, 0, 0, 0, 1);
    cyc();
    set_ex(16'h0099, 16'h0, 4'd1, 1, 0, 0, 0, 0);
    chk("hlt_done", mem_done, 1);
    chk("hlt_stall_n", stall_n, 0);
    chk("hlt_not_yet", halted, 0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("halt_done", mem_done, 0);
      chk("halt_halted", halted, 1);
      chk("halt_stall_n", stall_n, 0);
      chk("halt_hold", mem_hlt, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("hrst_halted", halted, 0);
    chk("hrst_stall_n", stall_n, 1);
    chk("hrst_valid", mem_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    mem_op(1'b0, 16'h0060, 16'h0, 5, 16'h0A0A);
    mem_op(1'b1, 16'h0070, 16'h1111, 2, 16'h0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("cnt_seven", stall_cycles, 7);
`else
    chk("cnt_tied", stall_cycles, 0);
`endif
    set_ex(16'h0080, 16'h0, 4'd5, 1, 0, 1, 1, 0);
    cyc();
    cyc();
    chk("mid_req", dmem.dmem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dmem.dmem_req, 0);
    chk("mid_rst_cnt", stall_cycles, 0);
    chk("mid_rst_stall_n", stall_n, 1);
    @(negedge clk);
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
